// File: rtl/bsg_manycore_link_to_axil_pkg.sv
// Shared AXI-Lite address map and types for the manycore-link AXI-Lite shell.
// The address map places one 4 KiB window per FIFO slot. Slot 0 starts at
// axil_m_slot_addr_gp. The register offsets inside each window follow the
// Xilinx AXI-Stream FIFO layout.
package bsg_manycore_link_to_axil_pkg;

  localparam int axil_base_addr_width_gp = 12;
  localparam int axil_slot_idx_width_gp  = 4;
  localparam logic [31:0] axil_m_slot_addr_gp = 32'h0000_1000;

  // register offsets within a slot window
  localparam logic [axil_base_addr_width_gp-1:0] axil_mm2s_ofs_isr_gp  = 12'h000;
  localparam logic [axil_base_addr_width_gp-1:0] axil_s2mm_ofs_rdfo_gp = 12'h01C;
  localparam logic [axil_base_addr_width_gp-1:0] axil_s2mm_ofs_rdfd_gp = 12'h020;

  // AXI read/write response codes
  localparam logic [1:0] axil_resp_okay_gp   = 2'b00;
  localparam logic [1:0] axil_resp_slverr_gp = 2'b10;
  localparam logic [1:0] axil_resp_decerr_gp = 2'b11;

  typedef enum logic [1:0] {
    E_RD_IDLE,
    E_RD_DATA,
    E_RD_RESP
  } rd_state_e;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } axil_rd_rsp_s;

endpackage

// File: rtl/bsg_axil_rxs.sv
// AXI-Lite read-side slave for num_fifos_p receive FIFO slots.
// A read of a slot's RDFD register pops one word from that slot's rx FIFO.
// A read of RDFO returns the slot's occupancy. A read of ISR returns the
// slot's interrupt status, and that read does not clear it.
// The slave holds one outstanding read at a time:
//   IDLE (arready) -> DATA (decode, pop) -> RESP (rvalid until rready).
// Ports:
//   clk_i, reset_i              clock, synchronous active-high reset
//   araddr_i/arvalid_i/arready_o  AXI-Lite read address channel
//   rdata_o/rresp_o/rvalid_o/rready_i  AXI-Lite read data channel
//   rxs_i/rxs_v_i/rxs_yumi_o    per-slot rx FIFO head, valid, pop strobe
//   rdfo_i                      per-slot occupancy count
//   isr_i                       per-slot interrupt status value
module bsg_axil_rxs
  import bsg_manycore_link_to_axil_pkg::*;
#(
  parameter int num_fifos_p  = 4,
  parameter int rdfo_width_p = 9
) (
  input  logic                                      clk_i,
  input  logic                                      reset_i,
  input  logic [31:0]                               araddr_i,
  input  logic                                      arvalid_i,
  output logic                                      arready_o,
  output logic [31:0]                               rdata_o,
  output logic [1:0]                                rresp_o,
  output logic                                      rvalid_o,
  input  logic                                      rready_i,
  input  logic [num_fifos_p-1:0][31:0]              rxs_i,
  input  logic [num_fifos_p-1:0]                    rxs_v_i,
  output logic [num_fifos_p-1:0]                    rxs_yumi_o,
  input  logic [num_fifos_p-1:0][rdfo_width_p-1:0]  rdfo_i,
  input  logic [num_fifos_p-1:0][31:0]              isr_i
);

  localparam int ofs_w = axil_base_addr_width_gp;
  localparam int idx_w = axil_slot_idx_width_gp;
  localparam logic [31:0] slot_base_full_lp = axil_m_slot_addr_gp >> ofs_w;
  localparam logic [idx_w:0] slot_base_lp = slot_base_full_lp[idx_w:0];

  rd_state_e     state_r;
  logic [31:0]   addr_r;
  axil_rd_rsp_s  rsp_r, rsp_n;

  // Only the slot and offset fields of the address take part in decode.
  logic _unused_addr_hi;
  assign _unused_addr_hi = &{1'b0, addr_r[31:ofs_w+idx_w], 1'b0};

  // The extra top bit holds the borrow, so addresses below the first slot
  // decode as a miss and do not wrap onto a high slot index.
  logic [idx_w:0]       idx_ext;
  logic [ofs_w-1:0]     ofs;
  assign idx_ext = {1'b0, addr_r[ofs_w +: idx_w]} - slot_base_lp;
  assign ofs     = addr_r[ofs_w-1:0];

  logic [num_fifos_p-1:0]        slot_hit;
  logic [num_fifos_p-1:0][31:0]  head_m, rdfo_m, isr_m;

  for (genvar i = 0; i < num_fifos_p; i++) begin : slot
    assign slot_hit[i] = ~idx_ext[idx_w] & (idx_ext[idx_w-1:0] == idx_w'(i));
    assign head_m[i]   = rxs_i[i]        & {32{slot_hit[i]}};
    assign rdfo_m[i]   = 32'(rdfo_i[i])  & {32{slot_hit[i]}};
    assign isr_m[i]    = isr_i[i]        & {32{slot_hit[i]}};
  end

  // slot_hit has at most one bit set, so OR-ing the masked words acts as a mux.
  logic [31:0] head_w, rdfo_w, isr_w;
  always_comb begin
    head_w = '0;
    rdfo_w = '0;
    isr_w  = '0;
    for (int i = 0; i < num_fifos_p; i++) begin
      head_w |= head_m[i];
      rdfo_w |= rdfo_m[i];
      isr_w  |= isr_m[i];
    end
  end

  logic any_hit, head_v, is_rdfd;
  assign any_hit = |slot_hit;
  assign head_v  = |(slot_hit & rxs_v_i);
  assign is_rdfd = (ofs == axil_s2mm_ofs_rdfd_gp);

  always_comb begin
    rsp_n = '{data: '0, resp: axil_resp_okay_gp};
    if (!any_hit) begin
      rsp_n.resp = axil_resp_decerr_gp;
    end else begin
      case (ofs)
        axil_s2mm_ofs_rdfd_gp: begin
          if (head_v) rsp_n.data = head_w;
          else        rsp_n.resp = axil_resp_slverr_gp;
        end
        axil_s2mm_ofs_rdfo_gp: rsp_n.data = rdfo_w;
        axil_mm2s_ofs_isr_gp:  rsp_n.data = isr_w;
        default: ;
      endcase
    end
  end

  // The pop is issued in the single DATA cycle. That is the same cycle in
  // which the head word is captured into rsp_r. RESP backpressure therefore
  // holds the captured copy and never pops a second time.
  assign rxs_yumi_o = (state_r == E_RD_DATA && !reset_i && is_rdfd)
                    ? (slot_hit & rxs_v_i) : '0;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= E_RD_IDLE;
      addr_r  <= '0;
      rsp_r   <= '0;
    end else begin
      case (state_r)
        E_RD_IDLE: if (arvalid_i) begin
          addr_r  <= araddr_i;
          state_r <= E_RD_DATA;
        end
        E_RD_DATA: begin
          rsp_r   <= rsp_n;
          state_r <= E_RD_RESP;
        end
        E_RD_RESP: if (rready_i) state_r <= E_RD_IDLE;
        default:   state_r <= E_RD_IDLE;
      endcase
    end
  end

  assign arready_o = (state_r == E_RD_IDLE) & ~reset_i;
  assign rvalid_o  = (state_r == E_RD_RESP);
  assign rdata_o   = rsp_r.data;
  assign rresp_o   = rsp_r.resp;

endmodule

// File: tb/tb_bsg_axil_rxs.sv
module tb_bsg_axil_rxs;
  import bsg_manycore_link_to_axil_pkg::*;

  localparam int NF = 4;
  localparam int RW = 9;
  localparam logic [11:0] ISR  = 12'h000;
  localparam logic [11:0] RDFO = 12'h01C;
  localparam logic [11:0] RDFD = 12'h020;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [31:0]              araddr;
  logic                     arvalid;
  logic                     arready;
  logic [31:0]              rdata;
  logic [1:0]               rresp;
  logic                     rvalid;
  logic                     rready;
  logic [NF-1:0][31:0]      rxs;
  logic [NF-1:0]            rxs_v;
  logic [NF-1:0]            rxs_yumi;
  logic [NF-1:0][RW-1:0]    rdfo;
  logic [NF-1:0][31:0]      isr;

  always #5 clk = ~clk;

  bsg_axil_rxs #(.num_fifos_p(NF), .rdfo_width_p(RW)) dut (
    .clk_i(clk), .reset_i(reset),
    .araddr_i(araddr), .arvalid_i(arvalid), .arready_o(arready),
    .rdata_o(rdata), .rresp_o(rresp), .rvalid_o(rvalid), .rready_i(rready),
    .rxs_i(rxs), .rxs_v_i(rxs_v), .rxs_yumi_o(rxs_yumi),
    .rdfo_i(rdfo), .isr_i(isr)
  );

  // reference model: one queue per rx FIFO plus the ISR values
  logic [31:0] q [NF][$];
  logic [31:0] isr_m [NF];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic update_rxs();
    for (int i = 0; i < NF; i++) begin
      rxs_v[i] = (q[i].size() > 0);
      rxs[i]   = (q[i].size() > 0) ? q[i][0] : $urandom;
      rdfo[i]  = RW'(q[i].size());
      isr[i]   = isr_m[i];
    end
  endtask

  function automatic logic [31:0] slot_addr(input int s, input logic [11:0] o);
    return (32'(s + 1) << 12) | {20'h0, o};
  endfunction

  task automatic push(input int s, input logic [31:0] w);
    q[s].push_back(w);
    update_rxs();
  endtask

  // One complete read, checked cycle by cycle against the model. The stall
  // argument is the number of RESP cycles held with rready low.
  task automatic axil_read(input logic [31:0] addr, input int stall);
    int slot;
    logic [11:0] o;
    bit hit;
    logic [31:0] ed;
    logic [1:0]  er;
    logic [NF-1:0] ey;
    slot = int'((addr >> 12) & 32'hF) - 1;
    o    = addr[11:0];
    hit  = (slot >= 0) && (slot < NF);
    ed = 0; er = axil_resp_okay_gp; ey = '0;
    if (!hit) er = axil_resp_decerr_gp;
    else if (o == RDFD) begin
      if (q[slot].size() > 0) begin ed = q[slot][0]; ey[slot] = 1'b1; end
      else er = axil_resp_slverr_gp;
    end
    else if (o == RDFO) ed = 32'(q[slot].size());
    else if (o == ISR)  ed = isr_m[slot];

    @(negedge clk);
    chk("arready_idle", 32'(arready), 1);
    araddr = addr; arvalid = 1'b1;
    @(posedge clk); #1 arvalid = 1'b0; araddr = $urandom;
    @(negedge clk);
    chk("rvalid_data", 32'(rvalid), 0);
    chk("arready_data", 32'(arready), 0);
    chk("yumi_data", 32'(rxs_yumi), 32'(ey));
    @(posedge clk); #1;
    if (ey != 0) void'(q[slot].pop_front());
    update_rxs();
    @(negedge clk);
    chk("rvalid_resp", 32'(rvalid), 1);
    chk("rdata", rdata, ed);
    chk("rresp", 32'(rresp), 32'(er));
    chk("yumi_resp", 32'(rxs_yumi), 0);
    for (int s = 0; s < stall; s++) begin
      if (hit && ($urandom_range(0, 1) == 1)) push(slot, $urandom);
      @(posedge clk);
      @(negedge clk);
      chk("bp_rvalid", 32'(rvalid), 1);
      chk("bp_rdata", rdata, ed);
      chk("bp_rresp", 32'(rresp), 32'(er));
      chk("bp_yumi", 32'(rxs_yumi), 0);
      chk("bp_arready", 32'(arready), 0);
    end
    rready = 1'b1;
    @(posedge clk); #1 rready = 1'b0;
    @(negedge clk);
    chk("done_rvalid", 32'(rvalid), 0);
    chk("done_arready", 32'(arready), 1);
  endtask

  initial begin
    reset = 1'b1; araddr = '0; arvalid = 1'b0; rready = 1'b0;
    for (int i = 0; i < NF; i++) isr_m[i] = $urandom;
    update_rxs();

    // T1 reset
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_arready", 32'(arready), 0);
      chk("rst_rvalid", 32'(rvalid), 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_rresp", 32'(rresp), 0);
      chk("rst_yumi", 32'(rxs_yumi), 0);
    end
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("post_rst_arready", 32'(arready), 1);

    // T2 pop
    push(0, 32'hCAFE_0001);
    axil_read(slot_addr(0, RDFD), 0);
    // T3 empty slot
    axil_read(slot_addr(1, RDFD), 0);
    // T4 backpressure, head changes while the response is held
    push(0, 32'hCAFE_0002);
    push(0, 32'hCAFE_0003);
    axil_read(slot_addr(0, RDFD), 5);
    // T5 occupancy and decode miss
    for (int k = 0; k < 37; k++) q[2].push_back($urandom);
    update_rxs();
    axil_read(slot_addr(2, RDFO), 0);
    axil_read(slot_addr(NF, RDFD), 1);
    axil_read(32'h0000_0020, 0);
    axil_read(slot_addr(3, ISR), 2);
    axil_read(slot_addr(3, ISR), 0);
    axil_read(slot_addr(1, 12'h004), 0);

    // T6 reset while the response is pending
    push(3, 32'h1234_5678);
    @(negedge clk);
    araddr = slot_addr(3, RDFD); arvalid = 1'b1;
    @(posedge clk); #1 arvalid = 1'b0;
    @(negedge clk);
    chk("t6_yumi", 32'(rxs_yumi), 32'(4'b1000));
    @(posedge clk); #1 void'(q[3].pop_front()); update_rxs();
    @(negedge clk);
    chk("t6_rvalid_pre", 32'(rvalid), 1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t6_rvalid_rst", 32'(rvalid), 0);
    chk("t6_yumi_rst", 32'(rxs_yumi), 0);
    chk("t6_arready_rst", 32'(arready), 0);
    @(posedge clk); #1 reset = 1'b0;
    axil_read(slot_addr(3, RDFD), 0);

    // randomized reads with random pushes and ISR updates
    for (int it = 0; it < 80; it++) begin
      int s;
      logic [11:0] o;
      if ($urandom_range(0, 2) == 0) push($urandom_range(0, NF-1), $urandom);
      if ($urandom_range(0, 4) == 0) begin
        isr_m[$urandom_range(0, NF-1)] = $urandom;
        update_rxs();
      end
      s = $urandom_range(0, NF + 1) - 1;
      case ($urandom_range(0, 4))
        0: o = ISR;
        1: o = RDFO;
        2, 3: o = RDFD;
        default: o = 12'($urandom);
      endcase
      axil_read(32'((s + 1) & 15) << 12 | {20'h0, o}, $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
